// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The arbiter connects to the slave modport.
// A requester/transmitter model connects to the master modport.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          tx_start_o;
    logic [DATA_WIDTH-1:0]         tx_data_o;
    logic                          tx_done_i;
    logic [NUM_REQ-1:0]            grant_o;
    logic                          busy_o;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  req_last_i,
        input  tx_done_i,
        output req_ready_o,
        output tx_start_o,
        output tx_data_o,
        output grant_o,
        output busy_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output req_last_i,
        output tx_done_i,
        input  req_ready_o,
        input  tx_start_o,
        input  tx_data_o,
        input  grant_o,
        input  busy_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// Each accepted byte is sent with a one-cycle start pulse.
// The next byte is taken only after the transmitter's done pulse.
// A grant lasts until end of message, a valid drop, or MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                rst_n_i,
    uart_tx_arbiter_if.slave    bus
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StWait
    } state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        ptr_q, ptr_d;
    logic [PtrW-1:0]        owner_q, owner_d;
    logic [CntW-1:0]        bcnt_q, bcnt_d;
    logic                   last_q, last_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   tx_start_q, tx_start_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;

    logic                   pick_found;
    logic [PtrW-1:0]        pick_idx;
    logic [PtrW-1:0]        next_ptr;
    logic                   owner_valid;
    logic                   owner_last;
    logic [DATA_WIDTH-1:0]  owner_data;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    // The loop runs downward so the closest candidate is written last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (bus.req_valid_i[(int'(ptr_q) + i) % int'(NUM_REQ)]) begin
                pick_found = 1'b1;
                pick_idx   = PtrW'((int'(ptr_q) + i) % int'(NUM_REQ));
            end
        end
    end

    // Signals of the current owner, plus the pointer value used on release.
    always_comb begin
        owner_valid = bus.req_valid_i[owner_q];
        owner_last  = bus.req_last_i[owner_q];
        owner_data  = bus.req_data_i[int'(owner_q) * int'(DATA_WIDTH) +: DATA_WIDTH];
        next_ptr    = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // Ready is asserted only in LOAD, and only toward the owner.
    always_comb begin
        bus.req_ready_o = '0;
        if (state_q == StLoad) begin
            bus.req_ready_o[owner_q] = owner_valid;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        bcnt_d     = bcnt_q;
        last_d     = last_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    bcnt_d            = '0;
                    state_d           = StLoad;
                end
            end
            StLoad: begin
                if (owner_valid) begin
                    tx_data_d  = owner_data;
                    last_d     = owner_last;
                    tx_start_d = 1'b1;
                    state_d    = StSend;
                end else begin
                    // Owner withdrew mid-message; it rejoins the normal rotation.
                    ptr_d   = next_ptr;
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            StSend: begin
                bcnt_d  = bcnt_q + 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (bus.tx_done_i) begin
                    if (last_q || (bcnt_q == CntW'(MAX_BURST))) begin
                        ptr_d   = next_ptr;
                        grant_d = '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            bcnt_q     <= '0;
            last_q     <= 1'b0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            bcnt_q     <= bcnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.tx_start_o = tx_start_q;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_uart_tx_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests    = 0;
    int   failures = 0;
    int   r1       = 0;

    logic [3:0] exp_g [0:6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
    logic [7:0] exp_d [0:6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h33, 8'h14, 8'h15};

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk     (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
        bus.req_valid_i[k]        = v;
        bus.req_data_i[k*8 +: 8] = d;
        bus.req_last_i[k]         = l;
    endtask

    // Poll for a start pulse with a cycle bound; timing out counts as a failure.
    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (bus.tx_start_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " start"}, {31'd0, bus.tx_start_o}, 32'd1);
    endtask

    // Called in SEND: move into WAIT, idle there, then give one done pulse.
    task automatic finish_byte(input int extra);
        tick();
        repeat (extra) tick();
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        bus.tx_done_i   = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst grant", bus.grant_o, 0);
        check("rst ready", bus.req_ready_o, 0);
        check("rst start", bus.tx_start_o, 0);
        check("rst data", bus.tx_data_o, 0);
        check("rst busy", bus.busy_o, 0);
        check("rst ptr", dut.ptr_q, 0);
        rst_n = 1'b1;
        tick();

        // Single requester: 0xA5 from req 0, done 20 cycles after start.
        set_req(0, 1'b1, 8'hA5, 1'b1);
        tick();
        check("single grant", bus.grant_o, 4'b0001);
        check("single ready", bus.req_ready_o, 4'b0001);
        check("single nostart", bus.tx_start_o, 0);
        tick();
        check("single start", bus.tx_start_o, 1);
        check("single data", bus.tx_data_o, 8'hA5);
        check("single send ready", bus.req_ready_o, 0);
        set_req(0, 1'b0, 8'h00, 1'b0);
        repeat (19) tick();
        check("single wait grant", bus.grant_o, 4'b0001);
        check("single wait start", bus.tx_start_o, 0);
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        check("single rel grant", bus.grant_o, 0);
        check("single rel busy", bus.busy_o, 0);
        check("single rel ptr", dut.ptr_q, 1);

        // Round-robin between req 0 and req 2, each sending 1-byte messages.
        do_reset();
        set_req(0, 1'b1, 8'h20, 1'b1);
        set_req(2, 1'b1, 8'h22, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_start("rr");
            check("rr grant", bus.grant_o, (i % 2 == 0) ? 4'b0001 : 4'b0100);
            check("rr data", bus.tx_data_o, (i % 2 == 0) ? 8'h20 : 8'h22);
            finish_byte(2);
            if (i == 0) check("rr ptr after 0", dut.ptr_q, 1);
            if (i == 1) check("rr ptr after 2", dut.ptr_q, 3);
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(2, 1'b0, 8'h00, 1'b0);
        tick();

        // Burst limit: req 1 streams 0x10..0x15, req 3 cuts in after four bytes.
        do_reset();
        r1 = 0;
        set_req(1, 1'b1, 8'h10, 1'b0);
        set_req(3, 1'b1, 8'h33, 1'b1);
        for (int i = 0; i < 7; i++) begin
            wait_start("burst");
            check("burst grant", bus.grant_o, exp_g[i]);
            check("burst data", bus.tx_data_o, exp_d[i]);
            if (exp_g[i] == 4'b0010) begin
                r1++;
                if (r1 == 6) set_req(1, 1'b0, 8'h00, 1'b0);
                else         set_req(1, 1'b1, 8'(8'h10 + r1), r1 == 5);
            end else begin
                set_req(3, 1'b0, 8'h00, 1'b0);
            end
            finish_byte(1);
            if (i == 0) check("burst continue ready", bus.req_ready_o, 4'b0010);
            if (i == 3) check("burst limit release", bus.grant_o, 0);
        end
        check("burst ptr", dut.ptr_q, 2);

        // Valid drop in LOAD after the first byte.
        set_req(2, 1'b1, 8'h40, 1'b0);
        wait_start("drop");
        check("drop grant", bus.grant_o, 4'b0100);
        check("drop data", bus.tx_data_o, 8'h40);
        set_req(2, 1'b0, 8'h00, 1'b0);
        finish_byte(0);
        check("drop load ready", bus.req_ready_o, 0);
        check("drop load grant", bus.grant_o, 4'b0100);
        tick();
        check("drop idle grant", bus.grant_o, 0);
        check("drop idle busy", bus.busy_o, 0);
        check("drop no start", bus.tx_start_o, 0);
        check("drop ptr", dut.ptr_q, 3);

        // Stray done pulses in IDLE and SEND.
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        check("stray idle busy", bus.busy_o, 0);
        check("stray idle ready", bus.req_ready_o, 0);
        set_req(0, 1'b1, 8'h55, 1'b1);
        wait_start("stray");
        check("stray grant", bus.grant_o, 4'b0001);
        check("stray data", bus.tx_data_o, 8'h55);
        set_req(0, 1'b0, 8'h00, 1'b0);
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        repeat (3) tick();
        check("stray wait grant", bus.grant_o, 4'b0001);
        check("stray wait busy", bus.busy_o, 1);
        check("stray wait ready", bus.req_ready_o, 0);
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        check("stray rel grant", bus.grant_o, 0);
        check("stray rel ptr", dut.ptr_q, 1);

        // Reset during WAIT with req 2 granted.
        set_req(2, 1'b1, 8'h66, 1'b1);
        wait_start("mrst");
        check("mrst grant", bus.grant_o, 4'b0100);
        set_req(2, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        check("mrst wait grant", bus.grant_o, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("mrst grant0", bus.grant_o, 0);
        check("mrst start0", bus.tx_start_o, 0);
        check("mrst busy0", bus.busy_o, 0);
        check("mrst ready0", bus.req_ready_o, 0);
        check("mrst data0", bus.tx_data_o, 0);
        check("mrst ptr0", dut.ptr_q, 0);
        tick();
        rst_n = 1'b1;
        set_req(3, 1'b1, 8'h77, 1'b1);
        tick();
        check("mrst regrant", bus.grant_o, 4'b1000);
        set_req(3, 1'b0, 8'h00, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
